// File: rtl/alu_seq_rv.sv
// RV32/64 integer ALU: single-cycle base/alternate ops, optional iterative multiply/divide.
// Define ALU_SEQ_MULDIV_EN to build the funct7=0x01 multiply/divide path.
module alu_seq_rv #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            enable,
   output logic            ready,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] register_data_1,
   input  logic [XLEN-1:0] register_data_2,
   output logic [XLEN-1:0] register_data_out,
   output logic            valid_out,
   output logic            illegal
);

   localparam int         SH_W    = CNT_W - 1;
   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   logic [XLEN-1:0] r_data_out;
   logic            r_valid;
   logic            r_illegal;

   logic            w_accept;
   logic [SH_W-1:0] w_shamt;
   logic [XLEN-1:0] w_alu;
   logic            w_illegal;
   logic            w_is_md;
   logic            w_md_done;
   logic [XLEN-1:0] w_md_result;

   assign w_accept = enable & ready;
   assign w_shamt  = register_data_2[SH_W-1:0];

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      w_alu     = '0;
      w_illegal = 1'b0;
      w_is_md   = 1'b0;
      case (funct7)
         F7_BASE: begin
            case (funct3)
               3'd0: w_alu = register_data_1 + register_data_2;
               3'd1: w_alu = register_data_1 << w_shamt;
               3'd2: w_alu = {{(XLEN-1){1'b0}}, $signed(register_data_1) < $signed(register_data_2)};
               3'd3: w_alu = {{(XLEN-1){1'b0}}, register_data_1 < register_data_2};
               3'd4: w_alu = register_data_1 ^ register_data_2;
               3'd5: w_alu = register_data_1 >> w_shamt;
               3'd6: w_alu = register_data_1 | register_data_2;
               3'd7: w_alu = register_data_1 & register_data_2;
            endcase
         end
         F7_ALT: begin
            case (funct3)
               3'd0:    w_alu = register_data_1 - register_data_2;
               3'd5:    w_alu = $unsigned($signed(register_data_1) >>> w_shamt);
               default: w_illegal = 1'b1;
            endcase
         end
`ifdef ALU_SEQ_MULDIV_EN
         7'h01:   w_is_md   = 1'b1;
`endif
         default: w_illegal = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MULDIV_EN
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

   state_t            r_state, w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_op;
   logic              r_neg;
   logic              r_dz;
   logic [XLEN-1:0]   r_rs1;
   logic [XLEN-1:0]   r_opnd;
   logic [2*XLEN-1:0] r_prod;

   logic              w_sgn1, w_sgn2, w_neg;
   logic [XLEN-1:0]   w_mag1, w_mag2;
   logic [XLEN:0]     w_mul_sum, w_rem_sh, w_diff;
   logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod_fin;
   logic [XLEN-1:0]   w_q, w_r;

   assign ready     = (r_state == IDLE);
   assign w_md_done = (r_state == BUSY) && (r_cnt == LAST_CNT);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (w_accept && w_is_md) w_state_next = BUSY;
         BUSY: if (w_md_done)           w_state_next = IDLE;
      endcase
   end

   // Both operations run on magnitudes; the sign is restored on the final step.
   assign w_sgn1 = (funct3 inside {3'd1, 3'd2, 3'd4, 3'd6}) & register_data_1[XLEN-1];
   assign w_sgn2 = (funct3 inside {3'd1, 3'd4, 3'd6}) & register_data_2[XLEN-1];
   assign w_mag1 = w_sgn1 ? -register_data_1 : register_data_1;
   assign w_mag2 = w_sgn2 ? -register_data_2 : register_data_2;
   assign w_neg  = (funct3 == 3'd6) ? w_sgn1 : (w_sgn1 ^ w_sgn2);

   assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_next = {w_mul_sum, r_prod[XLEN-1:1]};
   assign w_rem_sh   = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
   assign w_diff     = w_rem_sh - {1'b0, r_opnd};
   assign w_div_next = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_prod[XLEN-2:0], 1'b0}
                                    : {w_diff[XLEN-1:0],   r_prod[XLEN-2:0], 1'b1};

   assign w_prod_fin = r_neg ? -w_mul_next : w_mul_next;
   assign w_q        = w_div_next[XLEN-1:0];
   assign w_r        = w_div_next[2*XLEN-1:XLEN];

   always_comb begin
      w_md_result = '0;
      case (r_op)
         3'd0:             w_md_result = w_prod_fin[XLEN-1:0];
         3'd1, 3'd2, 3'd3: w_md_result = w_prod_fin[2*XLEN-1:XLEN];
         3'd4, 3'd5:       w_md_result = r_dz ? '1    : (r_neg ? -w_q : w_q);
         default:          w_md_result = r_dz ? r_rs1 : (r_neg ? -w_r : w_r);
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_op   <= '0;
         r_neg  <= 1'b0;
         r_dz   <= 1'b0;
         r_rs1  <= '0;
         r_opnd <= '0;
         r_prod <= '0;
      end else if (w_accept && w_is_md) begin
         r_cnt <= '0;
         r_op  <= funct3;
         r_neg <= w_neg;
         r_dz  <= (register_data_2 == '0);
         r_rs1 <= register_data_1;
         if (funct3[2]) begin
            r_prod <= {{XLEN{1'b0}}, w_mag1};
            r_opnd <= w_mag2;
         end else begin
            r_prod <= {{XLEN{1'b0}}, w_mag2};
            r_opnd <= w_mag1;
         end
      end else if (r_state == BUSY) begin
         r_cnt  <= r_cnt + CNT_W'(1);
         r_prod <= r_op[2] ? w_div_next : w_mul_next;
      end
   end
`else
   assign ready       = 1'b1;
   assign w_md_done   = 1'b0;
   assign w_md_result = '0;
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_data_out <= '0;
         r_valid    <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_valid   <= 1'b0;
         r_illegal <= 1'b0;
         if (w_accept && !w_is_md) begin
            r_valid    <= 1'b1;
            r_illegal  <= w_illegal;
            r_data_out <= w_illegal ? '0 : w_alu;
         end else if (w_md_done) begin
            r_valid    <= 1'b1;
            r_data_out <= w_md_result;
         end
      end
   end

   assign register_data_out = r_data_out;
   assign valid_out         = r_valid;
   assign illegal           = r_illegal;

endmodule
